dc_ipu_filter_taps_mac: RTL and testbench
=========================================

DC_IPU_FILTER_TAPS_MAC -- requirements
Module: dc_ipu_filter_taps_mac

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, unsigned pixel component width.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 12, signed weight width.
REQ-003 SHALL have parameter WEIGHT_FRACT_WIDTH, default 10, weight fractional bits (1.0 = 1<<WEIGHT_FRACT_WIDTH).
REQ-004 SHALL have port clk  input  1  sole clock; all registers on rising edge.
REQ-005 SHALL have port nreset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  global advance; low freezes every register, including state, window, pipeline and flags.
REQ-007 SHALL have port in_valid  input  1  in_pixel is presented this cycle.
REQ-008 SHALL have port in_pixel  input  PIXEL_WIDTH  unsigned source pixel.
REQ-009 SHALL have port in_sol  input  1  start of line; qualified by in_valid.
REQ-010 SHALL have port in_eol  input  1  end of line; qualified by in_valid.
REQ-011 SHALL have port calc  input  1  request one output sample from current window and weights.
REQ-012 SHALL have port weights  input  4 x WEIGHT_WIDTH signed  tap weights [0:3], from the cubic weight generator, aligned with calc.
REQ-013 SHALL have port out_valid  output  1  out_pixel valid.
REQ-014 SHALL have port out_pixel  output  PIXEL_WIDTH  filtered, rounded, clamped pixel.
REQ-015 SHALL have port err  output  1  sticky: calc received outside a line.

Function
REQ-016 SHALL hold a 4-entry window win[0:3]; win[3] is newest.
REQ-017 SHALL, on en & in_valid & in_sol, load all four entries with in_pixel (left-edge replication).
REQ-018 SHALL, on en & in_valid & !in_sol, shift: win[0..2] <= win[1..3], win[3] <= in_pixel.
REQ-019 SHALL implement FSM states IDLE and LINE; reset state IDLE.
REQ-020 SHALL transition IDLE->LINE on en & in_valid & in_sol & !in_eol.
REQ-021 SHALL transition LINE->IDLE on en & in_valid & in_eol; in_sol & in_eol together (1-pixel line) loads window and leaves/puts the FSM in IDLE.
REQ-022 SHALL, in LINE, accept in_valid without in_sol as a shift; in IDLE, in_valid without in_sol SHALL be ignored (no shift).
REQ-023 SHALL evaluate calc against the registered window and FSM state before any same-cycle pixel update.
REQ-024 SHALL, on en & calc in IDLE, drop the request and set err to 1; err clears only on reset.
REQ-025 SHALL, stage 1 (en & calc in LINE): register four products p[i] = {1'b0,win[i]} x weights[i], signed, width PIXEL_WIDTH+WEIGHT_WIDTH+1, plus valid bit.
REQ-026 SHALL, stage 2: sum the four products at width PIXEL_WIDTH+WEIGHT_WIDTH+3, add 1<<(WEIGHT_FRACT_WIDTH-1), arithmetic right shift by WEIGHT_FRACT_WIDTH.
REQ-027 SHALL clamp the shifted result: <0 -> 0; >2^PIXEL_WIDTH-1 -> 2^PIXEL_WIDTH-1; register into out_pixel with out_valid.
REQ-028 SHALL have latency exactly 2 enabled cycles from calc to out_valid; out_valid is a one-cycle pulse per accepted calc (held while en low).
REQ-029 SHALL accept back-to-back calc every enabled cycle with no bubbles.
REQ-030 SHALL not depend on weights summing to 1.0; out-of-range results are handled only by the clamp.

Reset
REQ-031 SHALL, on nreset low, asynchronously clear window to 0, FSM to IDLE, pipeline valids to 0, out_pixel to 0, out_valid to 0, err to 0.
REQ-032 SHALL, after reset mid-line, require a new in_sol before any calc is accepted; no stale samples emerge.

Verification (FRACT=10, PIXEL_WIDTH=8)
REQ-033 SHALL verify: sol 10, then 20,30,40; calc weights {0,1024,0,0} -> window [10,20,30,40], out_pixel 20, out_valid 2 cycles after calc.
REQ-034 SHALL verify: window [1,2,x,x], weights {512,512,0,0} -> 1.5 rounds to out_pixel 2.
REQ-035 SHALL verify clamp: window all 255, weights {-128,1280,0,0} -> 255; window [255,0,0,0], weights {-512,1536,0,0} -> 0.
REQ-036 SHALL verify: calc in IDLE -> no out_valid, err=1 and stays 1 until nreset.
REQ-037 SHALL verify: en low for 3 cycles with calc in flight -> out_valid delayed by 3 cycles, value unchanged; calc with same-cycle pixel uses pre-shift window.
REQ-038 SHALL verify: in_sol&in_eol single pixel 77 -> window [77,77,77,77], FSM IDLE; nreset mid-line -> all outputs 0, next calc flags err.

Source files
------------

// File: rtl/dc_ipu_filter_taps_mac.sv
// dc_ipu_filter_taps_mac
//   Four-tap horizontal MAC for the image processing unit. Keeps a sliding
//   4-pixel window of the current line. On request, it forms the weighted sum
//   of the window with the supplied cubic weights, then rounds, shifts and
//   clamps the result back to pixel range.
//
// Ports
//   clk        sole clock, rising edge
//   nreset     asynchronous active-low reset
//   en         global advance; low freezes every register
//   in_valid   in_pixel present this cycle (in_sol / in_eol qualified by it)
//   in_pixel   unsigned source pixel
//   in_sol     start of line: replicate pixel into the whole window
//   in_eol     end of line: return to IDLE after this pixel
//   calc       request one output sample from the registered window
//   weights    four signed tap weights, aligned with calc
//   out_valid  one-cycle pulse, 2 enabled cycles after an accepted calc
//   out_pixel  rounded, clamped filter result
//   err        sticky flag: calc arrived while no line was open
//
// Handshake: there is no backpressure. A transfer happens on any rising edge
// where en is high and in_valid (pixels) or calc (requests) is high.
// out_valid is a one-cycle pulse that the consumer must take when it sees it.
module dc_ipu_filter_taps_mac #(
  parameter int PIXEL_WIDTH        = 8,
  parameter int WEIGHT_WIDTH       = 12,
  parameter int WEIGHT_FRACT_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           en,
  input  logic                           in_valid,
  input  logic [PIXEL_WIDTH-1:0]         in_pixel,
  input  logic                           in_sol,
  input  logic                           in_eol,
  input  logic                           calc,
  input  logic signed [WEIGHT_WIDTH-1:0] weights [0:3],
  output logic                           out_valid,
  output logic [PIXEL_WIDTH-1:0]         out_pixel,
  output logic                           err
);

  localparam int PROD_W = PIXEL_WIDTH + WEIGHT_WIDTH + 1;
  localparam int SUM_W  = PIXEL_WIDTH + WEIGHT_WIDTH + 3;

  localparam logic signed [SUM_W-1:0] ROUND =
    {{(SUM_W-1){1'b0}}, 1'b1} << (WEIGHT_FRACT_WIDTH - 1);
  localparam logic signed [SUM_W-1:0] PIX_MAX =
    {{(SUM_W-PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LINE = 1'b1} state_e;

  state_e                    state_q,     state_d;
  logic [PIXEL_WIDTH-1:0]    win_q [0:3];
  logic [PIXEL_WIDTH-1:0]    win_d [0:3];
  logic signed [PROD_W-1:0]  prod_q [0:3];
  logic signed [PROD_W-1:0]  prod_d [0:3];
  logic                      s1_valid_q,  s1_valid_d;
  logic                      out_valid_q, out_valid_d;
  logic [PIXEL_WIDTH-1:0]    out_pixel_q, out_pixel_d;
  logic                      err_q,       err_d;

  logic                      calc_ok;
  logic signed [PROD_W-1:0]  pix_ext;
  logic signed [PROD_W-1:0]  wt_ext;
  logic signed [SUM_W-1:0]   sum_c;
  logic signed [SUM_W-1:0]   shifted;
  logic [PIXEL_WIDTH-1:0]    clamped;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    prod_d      = prod_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    err_d       = err_q;
    pix_ext     = '0;
    wt_ext      = '0;

    // calc looks at the registered window/state, so a pixel arriving in the
    // same cycle does not affect this sample.
    calc_ok = calc && (state_q == ST_LINE);

    // Stage 2 arithmetic: products are pre-extended by two guard bits so the
    // four-way sum cannot overflow.
    sum_c = '0;
    for (int i = 0; i < 4; i++) begin
      sum_c = sum_c + {{2{prod_q[i][PROD_W-1]}}, prod_q[i]};
    end
    shifted = (sum_c + ROUND) >>> WEIGHT_FRACT_WIDTH;
    if (shifted[SUM_W-1])          clamped = '0;
    else if (shifted > PIX_MAX)    clamped = {PIXEL_WIDTH{1'b1}};
    else                           clamped = shifted[PIXEL_WIDTH-1:0];

    if (en) begin
      // Stage 1: register the products.
      s1_valid_d = calc_ok;
      for (int i = 0; i < 4; i++) begin
        pix_ext   = {{WEIGHT_WIDTH{1'b0}}, win_q[i]};
        wt_ext    = {{(PIXEL_WIDTH+1){weights[i][WEIGHT_WIDTH-1]}}, weights[i]};
        prod_d[i] = pix_ext * wt_ext;
      end
      if (calc && (state_q == ST_IDLE)) err_d = 1'b1;

      // Stage 2: round, shift, clamp.
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_pixel_d = clamped;

      // Window and line state.
      if (in_valid) begin
        if (in_sol) begin
          for (int i = 0; i < 4; i++) win_d[i] = in_pixel;
          state_d = in_eol ? ST_IDLE : ST_LINE;
        end else if (state_q == ST_LINE) begin
          win_d[0] = win_q[1];
          win_d[1] = win_q[2];
          win_d[2] = win_q[3];
          win_d[3] = in_pixel;
          if (in_eol) state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < 4; i++) begin
        win_q[i]  <= '0;
        prod_q[i] <= '0;
      end
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      prod_q      <= prod_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dc_ipu_filter_taps_mac.sv
module tb_dc_ipu_filter_taps_mac;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              nreset;
  logic              en;
  logic              in_valid;
  logic [7:0]        in_pixel;
  logic              in_sol;
  logic              in_eol;
  logic              calc;
  logic signed [11:0] weights [0:3];
  logic              out_valid;
  logic [7:0]        out_pixel;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dc_ipu_filter_taps_mac #(
    .PIXEL_WIDTH(8), .WEIGHT_WIDTH(12), .WEIGHT_FRACT_WIDTH(10)
  ) dut (
    .clk(clk), .nreset(nreset), .en(en), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_sol(in_sol), .in_eol(in_eol), .calc(calc),
    .weights(weights), .out_valid(out_valid), .out_pixel(out_pixel), .err(err)
  );

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weights[0] = 12'(w0);
    weights[1] = 12'(w1);
    weights[2] = 12'(w2);
    weights[3] = 12'(w3);
  endtask

  task automatic push(input int p, input bit sol, input bit eol);
    in_valid = 1'b1; in_pixel = 8'(p); in_sol = sol; in_eol = eol;
    cyc();
    in_valid = 1'b0; in_sol = 1'b0; in_eol = 1'b0;
  endtask

  task automatic load_line(input int a, input int b, input int c, input int d);
    push(a, 1'b1, 1'b0);
    push(b, 1'b0, 1'b0);
    push(c, 1'b0, 1'b0);
    push(d, 1'b0, 1'b0);
  endtask

  // One calc, then observe the two following edges.
  task automatic one_calc(input string name, input int exp_pix);
    calc = 1'b1;
    cyc();
    calc = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s early_valid: got %0b want 0", name, out_valid);
    end
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_pixel !== 8'(exp_pix)) begin
      n_fail++;
      $display("FAIL %s result: got valid=%0b pix=%0d want valid=1 pix=%0d",
               name, out_valid, out_pixel, exp_pix);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nreset = 1'b0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || out_pixel !== 8'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b p=%0d e=%0b want 0/0/0", out_valid, out_pixel, err);
    end
    n_checks++;
    if (int'(dut.state_q) !== 0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", int'(dut.state_q));
    end
    nreset = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    int exp_w [0:3];
    exp_w = '{10, 20, 30, 40};
    load_line(10, 20, 30, 40);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut.win_q[i] !== 8'(exp_w[i])) begin
        n_fail++; $display("FAIL basic_window[%0d]: got %0d want %0d", i, dut.win_q[i], exp_w[i]);
      end
    end
    set_w(0, 1024, 0, 0);
    one_calc("basic_tap1", 20);
    cyc();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse: got %0b want 0", out_valid);
    end
    // -640 + 11520 + 17280 - 2560 = 25600; (25600+512)>>10 = 25
    set_w(-64, 576, 576, -64);
    one_calc("basic_4tap", 25);
  endtask

  task automatic test_round();
    load_line(1, 2, 9, 9);
    set_w(512, 512, 0, 0);   // 1.5 -> 2
    one_calc("round_half", 2);
  endtask

  task automatic test_clamp();
    push(255, 1'b1, 1'b0);
    set_w(-128, 1280, 0, 0); // 287 -> 255
    one_calc("clamp_high", 255);
    load_line(255, 0, 0, 0);
    set_w(-512, 1536, 0, 0); // -127 -> 0
    one_calc("clamp_low", 0);
  endtask

  task automatic test_back_to_back();
    load_line(255, 0, 0, 0);
    calc = 1'b1;
    set_w(1024, 0, 0, 0);
    cyc();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first: got %0b want 0", out_valid);
    end
    set_w(512, 0, 0, 0);
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_pixel !== 8'd255) begin
      n_fail++; $display("FAIL b2b_0: got v=%0b p=%0d want 1/255", out_valid, out_pixel);
    end
    set_w(-512, 1536, 0, 0);
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_pixel !== 8'd128) begin
      n_fail++; $display("FAIL b2b_1: got v=%0b p=%0d want 1/128", out_valid, out_pixel);
    end
    calc = 1'b0;
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_pixel !== 8'd0) begin
      n_fail++; $display("FAIL b2b_2: got v=%0b p=%0d want 1/0", out_valid, out_pixel);
    end
    cyc();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got %0b want 0", out_valid);
    end
  endtask

  task automatic test_enable();
    int exp_w [0:3];
    load_line(10, 20, 30, 40);
    set_w(0, 0, 1024, 0);
    calc = 1'b1;
    cyc();
    calc = 1'b0;
    en = 1'b0;
    in_valid = 1'b1; in_pixel = 8'd99;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_%0d: got valid %0b want 0", k, out_valid);
      end
    end
    in_valid = 1'b0;
    en = 1'b1;
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_pixel !== 8'd30) begin
      n_fail++; $display("FAIL stall_result: got v=%0b p=%0d want 1/30", out_valid, out_pixel);
    end
    exp_w = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut.win_q[i] !== 8'(exp_w[i])) begin
        n_fail++; $display("FAIL stall_window[%0d]: got %0d want %0d", i, dut.win_q[i], exp_w[i]);
      end
    end
    en = 1'b0;
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_pixel !== 8'd30) begin
      n_fail++; $display("FAIL stall_hold: got v=%0b p=%0d want 1/30", out_valid, out_pixel);
    end
    en = 1'b1;
    // calc with a same-cycle pixel must use the pre-shift window
    set_w(0, 0, 0, 1024);
    calc = 1'b1;
    in_valid = 1'b1; in_pixel = 8'd50;
    cyc();
    calc = 1'b0; in_valid = 1'b0;
    exp_w = '{20, 30, 40, 50};
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut.win_q[i] !== 8'(exp_w[i])) begin
        n_fail++; $display("FAIL shift_window[%0d]: got %0d want %0d", i, dut.win_q[i], exp_w[i]);
      end
    end
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_pixel !== 8'd40) begin
      n_fail++; $display("FAIL preshift_calc: got v=%0b p=%0d want 1/40", out_valid, out_pixel);
    end
  endtask

  task automatic test_single_pixel();
    push(77, 1'b1, 1'b1);
    push(5, 1'b0, 1'b0);     // ignored in IDLE
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut.win_q[i] !== 8'd77) begin
        n_fail++; $display("FAIL single_window[%0d]: got %0d want 77", i, dut.win_q[i]);
      end
    end
    n_checks++;
    if (int'(dut.state_q) !== 0) begin
      n_fail++; $display("FAIL single_state: got %0d want 0", int'(dut.state_q));
    end
  endtask

  task automatic test_idle_err();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_before: got %0b want 0", err);
    end
    set_w(1024, 0, 0, 0);
    calc = 1'b1;
    cyc();
    calc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b0 || err !== 1'b1) begin
        n_fail++; $display("FAIL idle_calc_%0d: got v=%0b e=%0b want 0/1", k, out_valid, err);
      end
      cyc();
    end
    load_line(3, 4, 5, 6);
    one_calc("err_line_calc", 3);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %0b want 1", err);
    end
  endtask

  task automatic test_reset_midline();
    load_line(100, 101, 102, 103);
    set_w(1024, 0, 0, 0);
    one_calc("pre_reset", 100);
    calc = 1'b1;
    cyc();
    calc = 1'b0;
    #2 nreset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_pixel !== 8'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%0b p=%0d e=%0b want 0/0/0", out_valid, out_pixel, err);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut.win_q[i] !== 8'd0) begin
        n_fail++; $display("FAIL midreset_window[%0d]: got %0d want 0", i, dut.win_q[i]);
      end
    end
    #2 nreset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL stale_%0d: got valid %0b want 0", k, out_valid);
      end
    end
    push(9, 1'b0, 1'b0);     // no in_sol yet: still IDLE
    calc = 1'b1;
    cyc();
    calc = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_err: got %0b want 1", err);
    end
    cyc();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_novalid: got %0b want 0", out_valid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    en = 1'b1; in_valid = 1'b0; in_pixel = '0; in_sol = 1'b0; in_eol = 1'b0;
    calc = 1'b0;
    set_w(0, 0, 0, 0);
    test_reset();
    test_basic();
    test_round();
    test_clamp();
    test_back_to_back();
    test_enable();
    test_single_pixel();
    test_idle_err();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
